// File: rtl/hx8352_init_sequencer_pkg.sv
// Shared definitions for the HX8352 init sequencer: script opcodes, ROM entry
// layout and controller state encoding.
package hx8352_init_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_CMD      = 3'b000,
    OP_DATA     = 3'b001,
    OP_DELAY_US = 3'b010,
    OP_DELAY_MS = 3'b011,
    OP_SET_RST  = 3'b100,
    OP_END      = 3'b111
  } opcode_e;

  // ROM word layout: [31:29] opcode, [28:16] reserved, [15:0] payload
  typedef struct packed {
    logic [2:0]  opcode;
    logic [12:0] rsvd;
    logic [15:0] payload;
  } entry_t;

  localparam int ENTRY_W   = 32;
  localparam int PAYLOAD_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_WRITE    = 4'd3,
    ST_DLY_STEP = 4'd4,
    ST_DLY_LOW  = 4'd5,
    ST_DLY_HIGH = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERROR    = 4'd8
  } state_e;

  function automatic logic is_terminal(input state_e st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERROR);
  endfunction

endpackage

// File: rtl/hx8352_init_sequencer_if.sv
// Sequencer-side bus bundle: init ROM port, LCD bus writer handshake and the
// microsecond delay unit interface.
interface hx8352_init_sequencer_if #(
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_is_cmd;
  logic [15:0]       wr_data;
  logic              dly_step;
  logic [15:0]       dly_us;
  logic              dly_done;

  modport master (
    output rom_addr,
    input  rom_data,
    output wr_valid,
    input  wr_ready,
    output wr_is_cmd,
    output wr_data,
    output dly_step,
    output dly_us,
    input  dly_done
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  wr_valid,
    output wr_ready,
    input  wr_is_cmd,
    input  wr_data,
    input  dly_step,
    input  dly_us,
    output dly_done
  );

endinterface

// File: rtl/hx8352_init_sequencer.sv
// Script-driven HX8352 power-up sequencer: walks the init ROM, issues bus
// writes, paces delays through the shared delay unit and drives the panel reset.
module hx8352_init_sequencer
  import hx8352_init_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int MS_US  = 1000
) (
  input  logic clk_1MHz,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic error,
  output logic lcd_rst_n,
  hx8352_init_sequencer_if.master bus
);

  state_e            state_r;
  state_e            state_s;
  state_e            adv_state_s;
  logic              start_d_r;
  logic              start_rise_s;
  logic              launch_s;
  logic              advance_s;
  logic              last_addr_s;
  entry_t            entry_s;
  logic [12:0]       unused_rsvd;

  logic [ADDR_W-1:0] rom_addr_r,  rom_addr_s;
  logic              busy_r,      busy_s;
  logic              done_r,      done_s;
  logic              error_r,     error_s;
  logic              wr_valid_r,  wr_valid_s;
  logic              wr_is_cmd_r, wr_is_cmd_s;
  logic [15:0]       wr_data_r,   wr_data_s;
  logic              dly_step_r,  dly_step_s;
  logic [15:0]       dly_us_r,    dly_us_s;
  logic              lcd_rst_r,   lcd_rst_s;
  logic [15:0]       ms_cnt_r,    ms_cnt_s;
  logic              is_ms_r,     is_ms_s;

  assign entry_s      = bus.rom_data;
  assign unused_rsvd  = entry_s.rsvd;
  assign start_rise_s = start & ~start_d_r;
  assign last_addr_s  = &rom_addr_r;
  // An advance past the last ROM slot has nowhere to go: the script overran.
  assign adv_state_s  = last_addr_s ? ST_ERROR : ST_FETCH;
  assign launch_s     = start_rise_s && !abort && is_terminal(state_r);
  // FETCH is entered only on launch or on an advance to the next entry.
  assign advance_s    = (state_s == ST_FETCH) && (state_r != ST_FETCH) && !launch_s;

  // State and output registers.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      start_d_r   <= 1'b0;
      rom_addr_r  <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      wr_valid_r  <= 1'b0;
      wr_is_cmd_r <= 1'b0;
      wr_data_r   <= 16'd0;
      dly_step_r  <= 1'b0;
      dly_us_r    <= 16'd0;
      lcd_rst_r   <= 1'b0;
      ms_cnt_r    <= 16'd0;
      is_ms_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      start_d_r   <= start;
      rom_addr_r  <= rom_addr_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      error_r     <= error_s;
      wr_valid_r  <= wr_valid_s;
      wr_is_cmd_r <= wr_is_cmd_s;
      wr_data_r   <= wr_data_s;
      dly_step_r  <= dly_step_s;
      dly_us_r    <= dly_us_s;
      lcd_rst_r   <= lcd_rst_s;
      ms_cnt_r    <= ms_cnt_s;
      is_ms_r     <= is_ms_s;
    end
  end

  // Next-state selection; abort overrides everything.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_rise_s) state_s = ST_FETCH;
          else              state_s = state_r;
        end
        ST_FETCH: state_s = ST_DECODE;
        ST_DECODE: begin
          case (entry_s.opcode)
            OP_CMD, OP_DATA: state_s = ST_WRITE;
            OP_SET_RST:      state_s = adv_state_s;
            OP_DELAY_US, OP_DELAY_MS: begin
              if (entry_s.payload == 16'd0) state_s = adv_state_s;
              else                          state_s = ST_DLY_STEP;
            end
            OP_END:  state_s = ST_DONE;
            default: state_s = ST_ERROR;
          endcase
        end
        ST_WRITE: begin
          if (bus.wr_ready) state_s = adv_state_s;
          else              state_s = ST_WRITE;
        end
        ST_DLY_STEP: state_s = ST_DLY_LOW;
        ST_DLY_LOW: begin
          if (!bus.dly_done) state_s = ST_DLY_HIGH;
          else               state_s = ST_DLY_LOW;
        end
        ST_DLY_HIGH: begin
          if (!bus.dly_done)                        state_s = ST_DLY_HIGH;
          else if (is_ms_r && (ms_cnt_r > 16'd1))   state_s = ST_DLY_STEP;
          else                                      state_s = adv_state_s;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and the delay bookkeeping.
  always_comb begin
    rom_addr_s  = rom_addr_r;
    busy_s      = busy_r;
    done_s      = done_r;
    error_s     = error_r;
    wr_valid_s  = wr_valid_r;
    wr_is_cmd_s = wr_is_cmd_r;
    wr_data_s   = wr_data_r;
    dly_step_s  = dly_step_r;
    dly_us_s    = dly_us_r;
    lcd_rst_s   = lcd_rst_r;
    ms_cnt_s    = ms_cnt_r;
    is_ms_s     = is_ms_r;
    if (abort) begin
      // The delay unit is left to finish on its own; only our side drops.
      wr_valid_s = 1'b0;
      dly_step_s = 1'b0;
      busy_s     = 1'b0;
    end else if (launch_s) begin
      rom_addr_s = '0;
      done_s     = 1'b0;
      error_s    = 1'b0;
      busy_s     = 1'b1;
    end else begin
      if (advance_s) rom_addr_s = rom_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      else           rom_addr_s = rom_addr_r;
      case (state_r)
        ST_DECODE: begin
          case (entry_s.opcode)
            OP_CMD, OP_DATA: begin
              wr_data_s   = entry_s.payload;
              wr_is_cmd_s = (entry_s.opcode == OP_CMD);
              wr_valid_s  = 1'b1;
            end
            OP_SET_RST: lcd_rst_s = entry_s.payload[0];
            OP_DELAY_US: begin
              if (entry_s.payload != 16'd0) begin
                dly_us_s = entry_s.payload;
                is_ms_s  = 1'b0;
              end else begin
                dly_us_s = dly_us_r;
              end
            end
            OP_DELAY_MS: begin
              if (entry_s.payload != 16'd0) begin
                ms_cnt_s = entry_s.payload;
                dly_us_s = 16'(MS_US);
                is_ms_s  = 1'b1;
              end else begin
                ms_cnt_s = ms_cnt_r;
              end
            end
            default: wr_valid_s = 1'b0;
          endcase
        end
        ST_WRITE: begin
          if (bus.wr_ready) wr_valid_s = 1'b0;
          else              wr_valid_s = 1'b1;
        end
        ST_DLY_STEP: dly_step_s = 1'b1;
        ST_DLY_LOW: begin
          if (!bus.dly_done) dly_step_s = 1'b0;
          else               dly_step_s = 1'b1;
        end
        ST_DLY_HIGH: begin
          if (bus.dly_done && is_ms_r && (ms_cnt_r > 16'd1)) ms_cnt_s = ms_cnt_r - 16'd1;
          else                                                ms_cnt_s = ms_cnt_r;
        end
        default: dly_step_s = dly_step_r;
      endcase
      if ((state_s == ST_DONE) && (state_r != ST_DONE)) begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end else if ((state_s == ST_ERROR) && (state_r != ST_ERROR)) begin
        busy_s  = 1'b0;
        error_s = 1'b1;
      end else begin
        busy_s = busy_s;
      end
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign lcd_rst_n     = lcd_rst_r;
  assign bus.rom_addr  = rom_addr_r;
  assign bus.wr_valid  = wr_valid_r;
  assign bus.wr_is_cmd = wr_is_cmd_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.dly_step  = dly_step_r;
  assign bus.dly_us    = dly_us_r;

endmodule

// File: tb/tb_hx8352_init_sequencer.sv
// Self-checking bench: registered ROM, stalling bus writer and delay unit
// models around the sequencer, with a script-level reference model.
`timescale 1ns/1ps
module tb_hx8352_init_sequencer;
  import hx8352_init_sequencer_pkg::*;

  localparam int ADDR_W = 8;
  localparam int MS_US  = 1000;
  localparam int DEPTH  = 256;

  logic clk_1MHz = 1'b0;
  logic rst_n    = 1'b0;
  logic start    = 1'b0;
  logic abort    = 1'b0;
  logic busy, done, error, lcd_rst_n;

  hx8352_init_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  hx8352_init_sequencer #(.ADDR_W(ADDR_W), .MS_US(MS_US)) dut (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .lcd_rst_n(lcd_rst_n),
    .bus      (bus)
  );

  always #500 clk_1MHz = ~clk_1MHz;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  initial forever begin
    @(posedge clk_1MHz);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- external block models ----------------
  logic [31:0] rom [DEPTH];
  logic [ADDR_W-1:0] rom_addr_q;

  function automatic logic [31:0] ent(input logic [2:0] op, input logic [15:0] pl);
    return {op, 13'd0, pl};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = ent(OP_END, 16'd0);
  endtask

  initial begin
    bus.rom_data = 32'd0;
    forever begin
      @(negedge clk_1MHz);
      rom_addr_q = bus.rom_addr;
      @(posedge clk_1MHz);
      #100;
      bus.rom_data = rom[rom_addr_q];
    end
  end

  int stall_left = 0;
  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk_1MHz);
      #100;
      if (bus.wr_valid && stall_left > 0) begin
        bus.wr_ready = 1'b0;
        stall_left--;
      end else begin
        bus.wr_ready = 1'b1;
      end
    end
  end

  // Delay unit: rising edge of dly_step drops done for dly_us cycles.
  int   dly_cnt = 0;
  logic step_prev = 1'b0;
  initial begin
    bus.dly_done = 1'b1;
    forever begin
      @(posedge clk_1MHz);
      #100;
      if (bus.dly_step === 1'b1 && step_prev === 1'b0) begin
        bus.dly_done = 1'b0;
        dly_cnt      = int'(bus.dly_us);
      end else if (!bus.dly_done) begin
        if (dly_cnt <= 1) bus.dly_done = 1'b1;
        else              dly_cnt--;
      end
      step_prev = bus.dly_step;
    end
  end

  // ---------------- script-level reference model ----------------
  logic [16:0] exp_wr [$];
  logic        exp_rst [$];
  logic [15:0] exp_dly [$];
  logic        exp_done, exp_err;
  logic        model_rst = 1'b0;

  task automatic build_model();
    logic        lvl;
    logic [2:0]  op;
    logic [15:0] pl;
    lvl = model_rst;
    exp_wr.delete(); exp_rst.delete(); exp_dly.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      op = rom[a][31:29];
      pl = rom[a][15:0];
      if (op == 3'b111) begin exp_done = 1'b1; break; end
      if (op == 3'b101 || op == 3'b110) begin exp_err = 1'b1; break; end
      case (op)
        3'b000: exp_wr.push_back({1'b1, pl});
        3'b001: exp_wr.push_back({1'b0, pl});
        3'b010: if (pl != 16'd0) exp_dly.push_back(pl);
        3'b011: for (int i = 0; i < int'(pl); i++) exp_dly.push_back(16'(MS_US));
        3'b100: if (pl[0] != lvl) begin lvl = pl[0]; exp_rst.push_back(lvl); end
        default: ;
      endcase
      if (a == DEPTH - 1) exp_err = 1'b1;
    end
    model_rst = lvl;
  endtask

  // ---------------- per-cycle compare ----------------
  logic        mon_on = 1'b0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_cmd = 1'b0;
  logic        prev_rst = 1'b0, prev_step = 1'b0;
  logic [15:0] prev_data = 16'd0;
  int          n_wr, n_stall, n_rise, first_rise_cyc, rst_rise_cyc;
  logic [16:0] wr_log [$];

  initial forever begin
    @(negedge clk_1MHz);
    if (mon_on) begin
      if (prev_valid && !prev_ready) begin
        check("wr_hold_valid", bus.wr_valid, 1);
        check("wr_hold_data", bus.wr_data, prev_data);
        check("wr_hold_cmd", bus.wr_is_cmd, prev_cmd);
      end
      if (bus.wr_valid && !bus.wr_ready) n_stall++;
      if (bus.wr_valid && bus.wr_ready) begin
        n_wr++;
        wr_log.push_back({bus.wr_is_cmd, bus.wr_data});
        if (exp_wr.size() == 0) check("wr_unexpected", {bus.wr_is_cmd, bus.wr_data}, 32'h1ffff);
        else                    check("wr_order", {bus.wr_is_cmd, bus.wr_data}, exp_wr.pop_front());
      end
      if (lcd_rst_n !== prev_rst) begin
        if (lcd_rst_n === 1'b1) rst_rise_cyc = cyc;
        if (exp_rst.size() == 0) check("rst_unexpected", lcd_rst_n, prev_rst);
        else                     check("rst_level", lcd_rst_n, exp_rst.pop_front());
      end
      if (bus.dly_step && !prev_step) begin
        n_rise++;
        if (n_rise == 1) first_rise_cyc = cyc;
        if (exp_dly.size() == 0) check("dly_unexpected", 1, 0);
        else                     check("dly_us", bus.dly_us, exp_dly.pop_front());
      end
      if (bus.wr_valid || bus.dly_step) check("busy_active", busy, 1);
      check("busy_vs_end", busy & (done | error), 0);
    end
    prev_valid = bus.wr_valid;
    prev_ready = bus.wr_ready;
    prev_cmd   = bus.wr_is_cmd;
    prev_data  = bus.wr_data;
    prev_rst   = lcd_rst_n;
    prev_step  = bus.dly_step;
  end

  int start_cyc, end_cyc;

  task automatic run_script(input string name, input int budget);
    int waited;
    build_model();
    n_wr = 0; n_stall = 0; n_rise = 0;
    first_rise_cyc = -1; rst_rise_cyc = -1;
    wr_log.delete();
    mon_on = 1'b1;
    @(negedge clk_1MHz);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk_1MHz);
    start = 1'b0;
    check({name, "_launch_busy"}, busy, 1);
    check({name, "_launch_addr"}, bus.rom_addr, 0);
    waited = 0;
    while (!(done || error) && waited < budget) begin
      @(negedge clk_1MHz);
      waited++;
    end
    end_cyc = cyc;
    if (!(done || error)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done/error after %0d cycles", name, budget);
    end
    check({name, "_done"}, done, exp_done);
    check({name, "_error"}, error, exp_err);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_wr_left"}, exp_wr.size(), 0);
    check({name, "_rst_left"}, exp_rst.size(), 0);
    check({name, "_dly_left"}, exp_dly.size(), 0);
    mon_on = 1'b0;
  endtask

  task automatic check_all_reset(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_error"}, error, 0);
    check({name, "_lcd_rst_n"}, lcd_rst_n, 0);
    check({name, "_rom_addr"}, bus.rom_addr, 0);
    check({name, "_wr_valid"}, bus.wr_valid, 0);
    check({name, "_wr_is_cmd"}, bus.wr_is_cmd, 0);
    check({name, "_wr_data"}, bus.wr_data, 0);
    check({name, "_dly_step"}, bus.dly_step, 0);
    check({name, "_dly_us"}, bus.dly_us, 0);
  endtask

  initial begin
    int waited;
    clear_rom();
    repeat (3) @(negedge clk_1MHz);
    check_all_reset("por");
    rst_n = 1'b1;
    @(negedge clk_1MHz);

    // Basic bring-up script
    clear_rom();
    rom[0] = ent(OP_SET_RST, 16'h0000);
    rom[1] = ent(OP_DELAY_US, 16'd10);
    rom[2] = ent(OP_SET_RST, 16'h0001);
    rom[3] = ent(OP_CMD, 16'h0022);
    rom[4] = ent(OP_DATA, 16'hABCD);
    run_script("basic", 200);
    check_range("basic_rst_low_span", rst_rise_cyc - start_cyc, 10, 100);
    check("basic_n_wr", n_wr, 2);
    if (wr_log.size() >= 2) begin
      check("basic_wr0", wr_log[0], 32'h1_0022);
      check("basic_wr1", wr_log[1], 32'h0_ABCD);
    end
    check("basic_lcd_high", lcd_rst_n, 1);

    // Bus writer stalls the first write for 5 cycles
    clear_rom();
    rom[0] = ent(OP_CMD, 16'h002C);
    rom[1] = ent(OP_DATA, 16'h1234);
    stall_left = 5;
    run_script("stall", 200);
    check("stall_cycles", n_stall, 5);
    check("stall_n_wr", n_wr, 2);
    if (wr_log.size() >= 1) check("stall_wr0", wr_log[0], 32'h1_002C);

    // Millisecond delay loop
    clear_rom();
    rom[0] = ent(OP_DELAY_MS, 16'd3);
    run_script("ms", 3500);
    check("ms_rises", n_rise, 3);
    check_range("ms_span", end_cyc - first_rise_cyc, 3000, 3030);

    // Zero-length delay is skipped
    clear_rom();
    rom[0] = ent(OP_DELAY_US, 16'd0);
    run_script("us0", 50);
    check("us0_rises", n_rise, 0);
    check_range("us0_latency", end_cyc - start_cyc, 1, 6);

    // Illegal opcode at address 2
    clear_rom();
    rom[0] = ent(OP_SET_RST, 16'h0001);
    rom[1] = ent(OP_CMD, 16'h0011);
    rom[2] = ent(3'b101, 16'h5555);
    rom[3] = ent(OP_DATA, 16'h5555);
    run_script("illegal", 100);
    check("illegal_error", error, 1);
    check("illegal_n_wr", n_wr, 1);

    // Script with no END overruns the ROM
    for (int i = 0; i < DEPTH; i++) rom[i] = ent(OP_SET_RST, 16'h0001);
    run_script("overrun", 1500);
    check("overrun_error", error, 1);
    check("overrun_addr", bus.rom_addr, 8'hFF);

    // Abort in the middle of a delay
    clear_rom();
    rom[0] = ent(OP_SET_RST, 16'h0001);
    rom[1] = ent(OP_DELAY_US, 16'd200);
    rom[2] = ent(OP_CMD, 16'h0033);
    rom[3] = ent(OP_DATA, 16'h0044);
    @(negedge clk_1MHz); start = 1'b1;
    @(negedge clk_1MHz); start = 1'b0;
    waited = 0;
    while (!bus.dly_step && waited < 50) begin @(negedge clk_1MHz); waited++; end
    check("abort_reached_dly", bus.dly_step, 1);
    abort = 1'b1;
    @(negedge clk_1MHz);
    abort = 1'b0;
    check("abort_dly_step", bus.dly_step, 0);
    check("abort_busy", busy, 0);
    check("abort_wr_valid", bus.wr_valid, 0);
    check("abort_lcd_kept", lcd_rst_n, 1);
    repeat (3) @(negedge clk_1MHz);
    check("abort_stays_idle", busy, 0);
    repeat (260) @(negedge clk_1MHz);

    // Reset pulse while a write is stalled
    stall_left = 1000;
    @(negedge clk_1MHz); start = 1'b1;
    @(negedge clk_1MHz); start = 1'b0;
    waited = 0;
    while (!bus.wr_valid && waited < 400) begin @(negedge clk_1MHz); waited++; end
    check("rst_reached_write", bus.wr_valid, 1);
    rst_n = 1'b0;
    #1;
    check_all_reset("async_rst");
    stall_left = 0;
    model_rst  = 1'b0;
    @(negedge clk_1MHz);
    rst_n = 1'b1;
    @(negedge clk_1MHz);
    run_script("rerun", 600);
    if (wr_log.size() >= 1) check("rerun_wr0", wr_log[0], 32'h1_0033);
    check("rerun_lcd_high", lcd_rst_n, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
